pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload width in bits (1..256).
REQ-002 SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer and 0 = single register.
REQ-003 SHALL have parameter RESET_VAL, default {WIDTH{1'b0}}, meaning the bubble payload driven after reset or flush.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the stall counter width.
REQ-005 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-006 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port in_valid  input  1  upstream beat present.
REQ-008 SHALL have port in_ready  output  1  block can accept a beat.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-010 SHALL have port flush  input  1  discard all held beats (pipeline kill).
REQ-011 SHALL have port out_valid  output  1  downstream beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-014 SHALL have port occupancy  output  2  count of held beats, 0..2.
REQ-015 SHALL have port stall_cnt  output  CNT_W  count of backpressured cycles.

Function
REQ-016 SHALL treat a beat as accepted when in_valid&&in_ready and as delivered when out_valid&&out_ready, both sampled at the rising edge of clk.
REQ-017 SHALL preserve FIFO order and SHALL NOT duplicate or drop beats, except on flush.
REQ-018 SHALL present an accepted beat on out_valid/out_data in the cycle after acceptance when it enters an empty block (latency 1).
REQ-019 SKID=1 SHALL implement a state machine with states EMPTY, ONE (main register full) and FULL (main and skid registers full), with occupancy encoded as 0, 1 and 2.
REQ-020 SKID=1 SHALL drive in_ready directly from a flop, with in_ready=1 in EMPTY and ONE and in_ready=0 in FULL, and with no combinational path from out_ready.
REQ-021 SKID=1 transitions SHALL be:
- EMPTY+accept -> ONE, main<=in_data.
- ONE+accept+deliver -> ONE, main<=in_data.
- ONE+accept only -> FULL, skid<=in_data.
- ONE+deliver only -> EMPTY.
- FULL+deliver -> ONE, main<=skid.
- All other cases hold state and data.
REQ-022 SKID=0 SHALL use one register with states EMPTY and ONE, and SHALL drive in_ready=!out_valid||out_ready combinationally.
REQ-023 SHALL drive out_valid=1 exactly in the ONE and FULL states, and SHALL drive out_data from the main register.
REQ-024 SHALL load the main register with RESET_VAL on every transition into EMPTY, so that out_data=RESET_VAL whenever out_valid=0.
REQ-025 flush=1 SHALL move the state to EMPTY and load main and skid with RESET_VAL at the next edge, and SHALL give out_valid=0 in the following cycle.
REQ-026 flush SHALL take priority over a simultaneous accept or deliver; a beat accepted in the flush cycle SHALL be discarded, while a beat delivered in the flush cycle counts as delivered.
REQ-027 stall_cnt SHALL increment by 1 on every cycle with out_valid&&!out_ready, SHALL saturate at 2^CNT_W-1 without wrapping, and SHALL NOT be cleared by flush.
REQ-028 changes in out_data or out_valid SHALL come only from a delivery, an accept into EMPTY, a flush or a reset, so that the payload holds stable while out_valid&&!out_ready.
REQ-029 SHALL produce no X on any output after the first reset edge, for any input sequence.

Reset
REQ-030 With rst=1 at an edge, the block SHALL set state=EMPTY, out_valid=0, out_data=RESET_VAL, skid=RESET_VAL, occupancy=0 and stall_cnt=0.
REQ-031 The reset values SHALL give in_ready=1 for SKID=1, and in_ready=1 for SKID=0, since out_valid=0.
REQ-032 rst SHALL override flush and all handshakes; a reset applied mid-transfer SHALL lose all held beats, and no beat SHALL be accepted in a reset cycle.

Verification
REQ-033 Pass-through, SKID=1, WIDTH=32: stream 0x1..0x8 with in_valid=1 and out_ready=1 -> out_data is 0x1..0x8 one cycle later, in_ready stays 1 and occupancy stays 1.
REQ-034 Skid fill: hold out_ready=0, send 0xA then 0xB -> after two edges occupancy=2 and in_ready=0; at the first edge with out_ready=1, 0xA is delivered; at the next, 0xB is delivered.
REQ-035 Flush priority: in FULL (0xA, 0xB), assert flush and in_valid with 0xC for one cycle -> the next cycle has out_valid=0, out_data=RESET_VAL and occupancy=0, and 0xC never appears.
REQ-036 Saturation, CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds; flush leaves stall_cnt at 15; rst sets it to 0.
REQ-037 SKID=0: out_ready=0 with one beat held -> in_ready=0 in the same cycle; raising out_ready raises in_ready in the same cycle, and an accept plus deliver in one cycle keeps occupancy=1.
REQ-038 Random: with random in_valid, out_ready and flush over 10k cycles for both SKID values, a scoreboard SHALL confirm order preserved, no loss except flushed beats, and out_data stable while stalled.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register: a two-entry skid buffer with a fully registered in_ready, or a
// single register. Also provides flush, an occupancy output and a saturating backpressure counter.
module pipe_skid_reg #(
    parameter int                 WIDTH     = 32,
    parameter int                 SKID      = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] main_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;
    logic             accept;
    logic             deliver;

    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] skid_q;
            logic             in_ready_q;

            // in_ready comes straight from a flop so upstream never sees out_ready combinationally.
            assign in_ready = in_ready_q;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    state_q    <= EMPTY;
                    main_q     <= RESET_VAL;
                    skid_q     <= RESET_VAL;
                    in_ready_q <= 1'b1;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (accept) begin
                                state_q <= ONE;
                                main_q  <= in_data;
                            end
                        end
                        ONE: begin
                            if (accept && deliver) begin
                                main_q <= in_data;
                            end else if (accept) begin
                                state_q    <= FULL;
                                skid_q     <= in_data;
                                in_ready_q <= 1'b0;
                            end else if (deliver) begin
                                state_q <= EMPTY;
                                main_q  <= RESET_VAL;
                            end
                        end
                        FULL: begin
                            if (deliver) begin
                                state_q    <= ONE;
                                main_q     <= skid_q;
                                skid_q     <= RESET_VAL;
                                in_ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state_q    <= EMPTY;
                            main_q     <= RESET_VAL;
                            skid_q     <= RESET_VAL;
                            in_ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            assign in_ready = !out_valid || out_ready;

            // An accept while holding a beat implies a simultaneous delivery, so ONE never overflows.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    state_q <= EMPTY;
                    main_q  <= RESET_VAL;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (accept) begin
                                state_q <= ONE;
                                main_q  <= in_data;
                            end
                        end
                        ONE: begin
                            if (accept) begin
                                main_q <= in_data;
                            end else if (deliver) begin
                                state_q <= EMPTY;
                                main_q  <= RESET_VAL;
                            end
                        end
                        default: begin
                            state_q <= EMPTY;
                            main_q  <= RESET_VAL;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Saturating counter; only rst clears it, flush does not.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

endmodule
